// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B bit serializer: pixel payload layout,
// FSM state encoding and default pulse timing at a 64 MHz system clock.
package ws2812b_pkg;

  // Pixel word geometry
  localparam int unsigned PIXEL_W   = 24;
  localparam int unsigned BIT_IDX_W = 5;

  // Default timing in clk cycles at 64 MHz
  localparam int unsigned T0H_CYC_DEF   = 26;     // 406 ns high for a 0 bit
  localparam int unsigned T1H_CYC_DEF   = 51;     // 797 ns high for a 1 bit
  localparam int unsigned BIT_CYC_DEF   = 80;     // 1.25 us bit period
  localparam int unsigned RESET_CYC_DEF = 19200;  // 300 us latch interval
  localparam int unsigned CNT_W_DEF     = 15;

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  // Pixel payload as delivered by the controller, sent G first, MSB first
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/ws2812b_tx_if.sv
// Pixel handshake between the WS2812B controller (master) and the bit
// serializer (slave).
//   valid   : master offers data_in/latch
//   latch   : follow this pixel with a strip latch interval
//   data_in : {G, R, B} pixel word
//   ready   : slave can accept a pixel this cycle
interface ws2812b_tx_if;
  import ws2812b_pkg::*;

  logic   valid;
  logic   latch;
  pixel_t data_in;
  logic   ready;

  modport master (
    output valid,
    output latch,
    output data_in,
    input  ready
  );

  modport slave (
    input  valid,
    input  latch,
    input  data_in,
    output ready
  );

endinterface

// File: rtl/ws2812b_tx.sv
// WS2812B single-wire NRZ serializer. Accepts one 24-bit GRB pixel per
// valid/ready handshake and shifts it out MSB first on led, optionally
// followed by a low latch interval.
//   clk   : system clock (64 MHz nominal)
//   reset : synchronous, active-high reset
//   bus   : pixel handshake (slave side): valid, latch, data_in, ready
//   led   : registered serial line to the strip
module ws2812b_tx
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H_CYC   = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC   = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC   = BIT_CYC_DEF,
  parameter int unsigned RESET_CYC = RESET_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ws2812b_tx_if.slave bus,
  output logic        led
);

  logic [1:0]           state_q,   state_nxt;
  logic [CNT_W-1:0]     cnt_q,     cnt_nxt;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_nxt;
  logic [PIXEL_W-1:0]   shift_q,   shift_nxt;
  logic                 latch_q,   latch_nxt;
  logic                 led_q;
  logic                 ready_q;

  logic                 high_done_c;
  logic                 bit_done_c;
  logic                 latch_done_c;

  // Phase-end detection; the current bit always sits in the shift MSB
  assign high_done_c  = shift_q[PIXEL_W-1] ? (cnt_q == CNT_W'(T1H_CYC - 1))
                                           : (cnt_q == CNT_W'(T0H_CYC - 1));
  assign bit_done_c   = (cnt_q == CNT_W'(BIT_CYC - 1));
  assign latch_done_c = (cnt_q == CNT_W'(RESET_CYC - 1));

  // Next-state logic
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    bit_idx_nxt = bit_idx_q;
    shift_nxt   = shift_q;
    latch_nxt   = latch_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          state_nxt   = S_HIGH;
          cnt_nxt     = '0;
          bit_idx_nxt = BIT_IDX_W'(PIXEL_W - 1);
          shift_nxt   = bus.data_in;
          latch_nxt   = bus.latch;
        end
      end

      S_HIGH: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        if (high_done_c) begin
          state_nxt = S_LOW;
        end
      end

      S_LOW: begin
        if (bit_done_c) begin
          cnt_nxt = '0;
          if (bit_idx_q != '0) begin
            state_nxt   = S_HIGH;
            bit_idx_nxt = bit_idx_q - BIT_IDX_W'(1);
            shift_nxt   = {shift_q[PIXEL_W-2:0], 1'b0};
          end else if (latch_q) begin
            state_nxt = S_LATCH;
            latch_nxt = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      S_LATCH: begin
        if (latch_done_c) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; led/ready are decoded from the next state
  // so both are plain flops aligned with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      latch_q   <= 1'b0;
      led_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      bit_idx_q <= bit_idx_nxt;
      shift_q   <= shift_nxt;
      latch_q   <= latch_nxt;
      led_q     <= (state_nxt == S_HIGH);
      ready_q   <= (state_nxt == S_IDLE);
    end
  end

  assign led       = led_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_ws2812b_tx.sv
// Self-checking bench for ws2812b_tx: a default-timing instance and a
// short-timing instance, checked against an arithmetic waveform model.
module tb_ws2812b_tx;
  import ws2812b_pkg::*;

  localparam int unsigned S_T0H = 4;
  localparam int unsigned S_T1H = 8;
  localparam int unsigned S_BIT = 12;
  localparam int unsigned S_RST = 20;

  logic clk;
  logic reset;
  logic led_d;
  logic led_s;

  int n_checks;
  int n_errors;

  ws2812b_tx_if bus_d ();
  ws2812b_tx_if bus_s ();

  ws2812b_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d),
    .led   (led_d)
  );

  ws2812b_tx #(
    .T0H_CYC   (S_T0H),
    .T1H_CYC   (S_T1H),
    .BIT_CYC   (S_BIT),
    .RESET_CYC (S_RST),
    .CNT_W     (6)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s),
    .led   (led_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [23:0] word;
    logic        latch;
    int          exp_high;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [23:0] w, input logic l);
    if (sel) begin
      bus_s.valid = v; bus_s.data_in = pixel_t'(w); bus_s.latch = l;
    end else begin
      bus_d.valid = v; bus_d.data_in = pixel_t'(w); bus_d.latch = l;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus_s.ready : bus_d.ready;
  endfunction

  function automatic logic get_led(input bit sel);
    return sel ? led_s : led_d;
  endfunction

  // Expected led level i cycles after the first rising cycle
  function automatic logic model_led(input bit sel, input logic [23:0] w, input int i);
    int bitc, t0h, t1h, k, off;
    logic b;
    bitc = sel ? int'(S_BIT) : int'(BIT_CYC_DEF);
    t0h  = sel ? int'(S_T0H) : int'(T0H_CYC_DEF);
    t1h  = sel ? int'(S_T1H) : int'(T1H_CYC_DEF);
    if (i >= 24 * bitc) return 1'b0;
    k   = i / bitc;
    off = i % bitc;
    b   = w[23 - k];
    return (off < (b ? t1h : t0h));
  endfunction

  // Cycles from handshake until ready is seen high again
  function automatic int exp_latency(input bit sel, input logic l);
    int bitc, rst;
    bitc = sel ? int'(S_BIT) : int'(BIT_CYC_DEF);
    rst  = sel ? int'(S_RST) : int'(RESET_CYC_DEF);
    return 24 * bitc + (l ? rst : 0) + 1;
  endfunction

  // Wait (bounded) for ready, then offer a word; handshake at the next posedge
  task automatic start(input bit sel, input logic [23:0] w, input logic l, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!get_ready(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(get_ready(sel) == 1'b1, {name, " idle_wait"}, int'(get_ready(sel)), 1);
    drive(sel, 1'b1, w, l);
  endtask

  // Sample one transaction from C+1 until ready returns
  task automatic check_pixel(input bit sel, input logic [23:0] w, input logic l,
                             input bit hold, input bit chain, input logic [23:0] chain_w,
                             input string name, output int high_cnt, output int lat,
                             output logic [23:0] held_w);
    int exp_lat;
    int first_bad;
    logic [23:0] rw;
    exp_lat   = exp_latency(sel, l);
    first_bad = -1;
    high_cnt  = 0;
    lat       = 0;
    held_w    = w;
    for (int i = 0; i < exp_lat + 50; i++) begin
      @(negedge clk);
      if (i == 0) chk(get_ready(sel) == 1'b0, {name, " ready_fall"}, int'(get_ready(sel)), 0);
      if (get_ready(sel)) begin
        lat = i + 1;
        chk(get_led(sel) == 1'b0, {name, " idle_led"}, int'(get_led(sel)), 0);
        break;
      end
      if (get_led(sel)) high_cnt++;
      if (get_led(sel) !== model_led(sel, w, i) && first_bad < 0) first_bad = i;
      if (hold) begin
        rw     = 24'($urandom);
        held_w = rw;
        drive(sel, 1'b1, rw, 1'b1);
      end else if (i == 0) begin
        drive(sel, 1'b0, 24'h0, 1'b0);
      end
    end
    chk(first_bad < 0, {name, " wave_first_bad_cycle"}, first_bad, -1);
    chk(lat == exp_lat, {name, " ready_latency"}, lat, exp_lat);
    if (chain) drive(sel, 1'b1, chain_w, 1'b0);
  endtask

  initial begin
    int hc, lat, bad;
    logic [23:0] hw, w;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{word: 24'h800001, latch: 1'b0, exp_high: 674,  exp_lat: 1921};
    vecs[1] = '{word: 24'h000000, latch: 1'b1, exp_high: 624,  exp_lat: 21121};
    vecs[2] = '{word: 24'hFFFFFF, latch: 1'b0, exp_high: 1224, exp_lat: 1921};
    vecs[3] = '{word: 24'h0F0F0F, latch: 1'b0, exp_high: 924,  exp_lat: 1921};
    vecs[4] = '{word: 24'h123456, latch: 1'b0, exp_high: 849,  exp_lat: 1921};

    drive(1'b0, 1'b0, 24'h0, 1'b0);
    drive(1'b1, 1'b0, 24'h0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk(led_d == 1'b0, "reset led", int'(led_d), 0);
    chk(bus_d.ready == 1'b1, "reset ready", int'(bus_d.ready), 1);
    chk(led_s == 1'b0, "reset led_s", int'(led_s), 0);
    chk(bus_s.ready == 1'b1, "reset ready_s", int'(bus_s.ready), 1);
    reset = 1'b0;

    // Table-driven vectors with hand-computed pulse totals and latencies
    for (int v = 0; v < 5; v++) begin
      start(1'b0, vecs[v].word, vecs[v].latch, $sformatf("vec%0d", v));
      check_pixel(1'b0, vecs[v].word, vecs[v].latch, 1'b0, 1'b0, 24'h0,
                  $sformatf("vec%0d", v), hc, lat, hw);
      chk(hc == vecs[v].exp_high, $sformatf("vec%0d high_total", v), hc, vecs[v].exp_high);
      chk(lat == vecs[v].exp_lat, $sformatf("vec%0d table_latency", v), lat, vecs[v].exp_lat);
    end

    // Random words against the model
    for (int r = 0; r < 4; r++) begin
      w = 24'($urandom);
      start(1'b0, w, 1'b0, $sformatf("rand%0d", r));
      check_pixel(1'b0, w, 1'b0, 1'b0, 1'b0, 24'h0, $sformatf("rand%0d", r), hc, lat, hw);
    end

    // valid held with changing data: only the captured word is sent, the
    // next capture happens on the first ready cycle
    start(1'b0, 24'hA5C33C, 1'b0, "hold");
    check_pixel(1'b0, 24'hA5C33C, 1'b0, 1'b1, 1'b0, 24'h0, "hold", hc, lat, hw);
    check_pixel(1'b0, hw, 1'b1, 1'b0, 1'b0, 24'h0, "hold_second", hc, lat, w);

    // Back-to-back pixels, valid reasserted the cycle ready rises
    start(1'b0, 24'hFF00FF, 1'b0, "b2b_a");
    check_pixel(1'b0, 24'hFF00FF, 1'b0, 1'b0, 1'b1, 24'h00FF00, "b2b_a", hc, lat, hw);
    check_pixel(1'b0, 24'h00FF00, 1'b0, 1'b0, 1'b0, 24'h0, "b2b_b", hc, lat, hw);

    // Reset in the high phase of the 14th bit sent (bit index 10)
    start(1'b0, 24'hC3C3C3, 1'b0, "rst_mid");
    bad = 0;
    for (int i = 0; i <= 13 * 80 + 10; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b0, 24'h0, 1'b0);
      if (led_d !== model_led(1'b0, 24'hC3C3C3, i)) bad++;
    end
    chk(bad == 0 && led_d == 1'b1, "rst_mid pre_wave", bad, 0);
    reset = 1'b1;
    drive(1'b0, 1'b1, 24'hFFFFFF, 1'b1);
    @(negedge clk);
    chk(led_d == 1'b0, "rst_mid led", int'(led_d), 0);
    chk(bus_d.ready == 1'b1, "rst_mid ready", int'(bus_d.ready), 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 24'h0, 1'b0);
    @(negedge clk);
    chk(bus_d.ready == 1'b1 && led_d == 1'b0, "rst_valid no_capture", int'(bus_d.ready), 1);
    start(1'b0, 24'h5A5A5A, 1'b0, "post_rst");
    check_pixel(1'b0, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 24'h0, "post_rst", hc, lat, hw);

    // Short-timing instance with latch tail
    start(1'b1, 24'hAAAAAA, 1'b1, "small");
    check_pixel(1'b1, 24'hAAAAAA, 1'b1, 1'b0, 1'b0, 24'h0, "small", hc, lat, hw);
    chk(hc == 144, "small high_total", hc, 144);
    chk(lat == 309, "small table_latency", lat, 309);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
